// File: rtl/normalizing_pkg.sv
// Shared FP-add constants and types: widths, magnitude slot positions,
// the exponent ceiling and the normalizer state encoding. The rounding
// stage imports the same package so both stages agree on the layout.
package normalizing_pkg;

    localparam int EXP_W      = 8;    // exponent width; incre is EXP_W+1 bits
    localparam int MAG_W      = 27;   // carry + hidden one + fraction/guard/sticky
    localparam int CARRY_BIT  = 26;   // set when the adder produced a carry out
    localparam int HIDDEN_BIT = 25;   // position of the leading one once normalized
    localparam int EXP_MAX    = 255;  // incremented exponent at or above this overflows

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } norm_state_t;

endpackage

// File: rtl/normalizing.sv
// Post-add normalizer: takes the raw magnitude sum and common exponent,
// corrects a carry with a single right shift (keeping sticky), or walks a
// leading one up to the hidden slot one bit per cycle, flushing to zero when
// the exponent would drop below 1. The result is held until consumed.
module normalizing #(
    parameter int EXP_W = normalizing_pkg::EXP_W,
    parameter int MAG_W = normalizing_pkg::MAG_W
) (
    input  logic             clk,
    input  logic             res,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [MAG_W-1:0] in_mag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAG_W:0]   shift,
    output logic [EXP_W:0]   incre,
    output logic             underflow
);
    import normalizing_pkg::*;

    norm_state_t        state_reg;
    logic               sign_reg;
    logic [EXP_W:0]     exp_reg;
    logic [MAG_W-1:0]   mag_reg;

    logic [EXP_W:0]     exp_inc;
    logic               exp_ovf;
    logic [MAG_W-1:0]   mag_rshift;

    // Carry correction: drop one bit, folding the two lowest bits into sticky.
    always_comb begin
        exp_inc    = exp_reg + (EXP_W+1)'(1);
        exp_ovf    = (exp_inc >= (EXP_W+1)'(EXP_MAX));
        mag_rshift = {1'b0, mag_reg[MAG_W-1:2], mag_reg[1] | mag_reg[0]};
    end

    // Only the idle state can take a new sum; DONE->IDLE edge never accepts.
    assign in_ready = (state_reg == IDLE);

    // Normalizer FSM with the shift/exponent datapath and registered outputs.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_reg <= IDLE;
            sign_reg  <= 1'b0;
            exp_reg   <= '0;
            mag_reg   <= '0;
            shift     <= '0;
            incre     <= '0;
            underflow <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        sign_reg  <= in_sign;
                        exp_reg   <= {1'b0, in_exp};
                        mag_reg   <= in_mag;
                        state_reg <= NORM;
                    end
                end
                NORM: begin
                    if (mag_reg == '0) begin
                        // Exact cancellation: true zero, not an underflow.
                        shift     <= '0;
                        incre     <= '0;
                        underflow <= 1'b0;
                        out_valid <= 1'b1;
                        state_reg <= DONE;
                    end else if (mag_reg[CARRY_BIT]) begin
                        shift     <= {sign_reg, mag_rshift};
                        incre     <= {exp_ovf, exp_inc[EXP_W-1:0]};
                        underflow <= 1'b0;
                        out_valid <= 1'b1;
                        state_reg <= DONE;
                    end else if (mag_reg[HIDDEN_BIT]) begin
                        shift     <= {sign_reg, mag_reg};
                        incre     <= {1'b0, exp_reg[EXP_W-1:0]};
                        underflow <= 1'b0;
                        out_valid <= 1'b1;
                        state_reg <= DONE;
                    end else if (exp_reg > (EXP_W+1)'(1)) begin
                        // One bit per cycle keeps the shifter to a single mux level.
                        mag_reg <= {mag_reg[MAG_W-2:0], 1'b0};
                        exp_reg <= exp_reg - (EXP_W+1)'(1);
                    end else begin
                        // Exponent exhausted before the leading one arrived: flush.
                        shift     <= '0;
                        incre     <= '0;
                        underflow <= 1'b1;
                        out_valid <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
